// File: rtl/button_press_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types, constants and BCD helpers for the push-button press timer.
//   state_t   : controller FSM states
//   BCD_MAX   : saturation value of the 4-digit BCD duration counter
//   to_bcd2   : integer -> 16-bit BCD preload (clamped to 0..9999)
//   bcd_inc   : 4-digit BCD +1 with per-digit carry (caller prevents 9999+1)
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        TIMING     = 3'd2,
        RELEASE_DB = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    function automatic logic [15:0] to_bcd2(input int value);
        int v;
        v = (value < 0) ? 0 : ((value > 9999) ? 9999 : value);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] res;
        logic        carry;
        res   = value;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                // A digit at 9 rolls to 0 and passes the carry upward.
                if (res[d*4 +: 4] == 4'd9) begin
                    res[d*4 +: 4] = 4'd0;
                end else begin
                    res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/button_press_timer_ctrl_bcd4_counter.sv
// -----------------------------------------------------------------------------
// bcd4_counter
// Four-digit saturating BCD counter with synchronous load.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (wins over inc)
//   load_val  : 16-bit BCD value to load
//   inc       : add one in BCD, holding at 9999
//   count     : registered BCD count
//   sat       : registered flag, count == 9999
// -----------------------------------------------------------------------------
module bcd4_counter
    import button_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] count,
    output logic        sat
);

    logic [15:0] count_r;
    logic        sat_r;
    logic [15:0] next_s;

    // Next count: load has priority, increment stops at 9999.
    always_comb begin
        next_s = count_r;
        if (load) begin
            next_s = load_val;
        end else if (inc && (count_r != BCD_MAX)) begin
            next_s = bcd_inc(count_r);
        end else begin
            next_s = count_r;
        end
    end

    // Count register and its saturation flag, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 16'h0000;
            sat_r   <= 1'b0;
        end else begin
            count_r <= next_s;
            sat_r   <= (next_s == BCD_MAX);
        end
    end

    assign count = count_r;
    assign sat   = sat_r;

endmodule

// File: rtl/button_press_timer_ctrl.sv
// -----------------------------------------------------------------------------
// button_press_timer_ctrl
// Measures how long a push-button is held, in ticks of TICK_DIV clocks,
// with debounce on both press and release, and publishes a BCD result.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   button_input : raw asynchronous button level, 1 = pressed
//   time_display : last measured duration, 4 BCD digits (max 9999)
//   valid        : one-cycle pulse when time_display is updated
//   busy         : high from confirmed press until the result is published
//   overflow     : the last or current measurement saturated at 9999
// -----------------------------------------------------------------------------
module button_press_timer_ctrl
    import button_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_input,
    output logic [15:0] time_display,
    output logic        valid,
    output logic        busy,
    output logic        overflow
);

    localparam int              TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [6:0]      DB_LAST   = 7'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0]     DB_BCD    = to_bcd2(DEBOUNCE_TICKS);

    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic              sync1_r;
    logic              btn_sync_r;
    state_t            state_r;
    logic [6:0]        db_cnt_r;
    logic [15:0]       snapshot_r;
    logic [15:0]       display_r;
    logic              valid_r;
    logic              busy_r;
    logic              overflow_r;
    logic              bcd_load_s;
    logic              bcd_inc_s;
    logic [15:0]       bcd_count_s;
    logic              bcd_sat_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Free-running tick divider, 0..TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Two-flop synchroniser on the raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            sync1_r    <= button_input;
            btn_sync_r <= sync1_r;
        end
    end

    // Counter control: preload the debounce time when a press is confirmed,
    // and keep counting ticks through the release debounce window.
    always_comb begin
        bcd_load_s = 1'b0;
        bcd_inc_s  = 1'b0;
        if ((state_r == PRESS_DB) && btn_sync_r && tick_s && (db_cnt_r == DB_LAST)) begin
            bcd_load_s = 1'b1;
        end else begin
            bcd_load_s = 1'b0;
        end
        if ((state_r == TIMING) || (state_r == RELEASE_DB)) begin
            bcd_inc_s = tick_s;
        end else begin
            bcd_inc_s = 1'b0;
        end
    end

    bcd4_counter u_bcd (
        .clk      (clk),
        .rst      (rst),
        .load     (bcd_load_s),
        .load_val (DB_BCD),
        .inc      (bcd_inc_s),
        .count    (bcd_count_s),
        .sat      (bcd_sat_s)
    );

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            db_cnt_r   <= 7'd0;
            snapshot_r <= 16'h0000;
            display_r  <= 16'h0000;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (((state_r == TIMING) || (state_r == RELEASE_DB)) && bcd_sat_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (btn_sync_r) begin
                        state_r  <= PRESS_DB;
                        db_cnt_r <= 7'd0;
                    end
                end
                PRESS_DB: begin
                    // A level change beats a coincident tick.
                    if (!btn_sync_r) begin
                        state_r <= IDLE;
                    end else if (tick_s) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_r    <= TIMING;
                            busy_r     <= 1'b1;
                            overflow_r <= 1'b0;
                        end else begin
                            db_cnt_r <= db_cnt_r + 7'd1;
                        end
                    end
                end
                TIMING: begin
                    if (!btn_sync_r) begin
                        state_r    <= RELEASE_DB;
                        db_cnt_r   <= 7'd0;
                        snapshot_r <= bcd_count_s;
                    end
                end
                RELEASE_DB: begin
                    if (btn_sync_r) begin
                        state_r <= TIMING;
                    end else if (tick_s) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_r <= DONE;
                        end else begin
                            db_cnt_r <= db_cnt_r + 7'd1;
                        end
                    end
                end
                DONE: begin
                    display_r <= snapshot_r;
                    valid_r   <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign time_display = display_r;
    assign valid        = valid_r;
    assign busy         = busy_r;
    assign overflow     = overflow_r;

endmodule
